// File: rtl/pulse_gen_pkg.sv
// Shared types and default sizing for the pulse train generator.
// The state encoding is visible here so tooling can decode state_q by name.
package pulse_gen_pkg;

  localparam int DEF_MAX_PULSES = 8;
  localparam int DEF_PERIOD_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter timing one HIGH or LOW phase; expired flags the last cycle.
// Load has priority over enable; the counter parks at zero instead of wrapping.
module phase_timer #(
  parameter int PERIOD_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] load_val,
  output logic                expired
);

  logic [PERIOD_W-1:0] cnt_q;
  logic [PERIOD_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (enable && (cnt_q != '0)) begin
      cnt_d = cnt_q - PERIOD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == PERIOD_W'(1));

endmodule

// File: rtl/pulse_train_gen.sv
// Emits a burst of N registered pulses, H cycles high and L cycles low, on a one-cycle start.
// Every output is a flop computed from the next state, so no input reaches an output combinationally.
module pulse_train_gen
  import pulse_gen_pkg::*;
#(
  parameter int MAX_PULSES = DEF_MAX_PULSES,
  parameter int PERIOD_W   = DEF_PERIOD_W,
  parameter int CNT_W      = $clog2(MAX_PULSES + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [CNT_W-1:0]    num_pulses,
  input  logic [PERIOD_W-1:0] high_cycles,
  input  logic [PERIOD_W-1:0] low_cycles,
  output logic                pulse_out,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    sent
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PULSES);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    num_q, num_d;
  logic [PERIOD_W-1:0] high_q, high_d;
  logic [PERIOD_W-1:0] low_q, low_d;
  logic [CNT_W-1:0]    sent_q, sent_d;
  logic                pulse_out_q, pulse_out_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                accept;
  logic [CNT_W-1:0]    num_clamp;
  logic [PERIOD_W-1:0] high_fix;
  logic [PERIOD_W-1:0] low_fix;

  logic                tmr_load;
  logic                tmr_enable;
  logic [PERIOD_W-1:0] tmr_val;
  logic                tmr_expired;

  assign accept    = (state_q == ST_IDLE) && start;
  assign num_clamp = (num_pulses > MAX_CNT) ? MAX_CNT : num_pulses;
  assign high_fix  = (high_cycles == '0) ? PERIOD_W'(1) : high_cycles;
  assign low_fix   = (low_cycles == '0) ? PERIOD_W'(1) : low_cycles;

  phase_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_phase_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .enable   (tmr_enable),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Abort is tested before phase expiry so it wins a same-cycle collision.
  always_comb begin
    state_d    = state_q;
    tmr_load   = 1'b0;
    tmr_enable = 1'b0;
    tmr_val    = high_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = (num_clamp != '0) ? ST_HIGH : ST_DONE;
          tmr_load = 1'b1;
          tmr_val  = high_fix;
        end
      end
      ST_HIGH: begin
        if (abort) begin
          state_d = ST_DONE;
        end else if (tmr_expired) begin
          if (sent_q < num_q) begin
            state_d  = ST_LOW;
            tmr_load = 1'b1;
            tmr_val  = low_q;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          tmr_enable = 1'b1;
        end
      end
      ST_LOW: begin
        if (abort) begin
          state_d = ST_DONE;
        end else if (tmr_expired) begin
          state_d  = ST_HIGH;
          tmr_load = 1'b1;
          tmr_val  = high_q;
        end else begin
          tmr_enable = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    pulse_out_d = (state_d == ST_HIGH);
    busy_d      = (state_d == ST_HIGH) || (state_d == ST_LOW);
    done_d      = (state_d == ST_DONE);
  end

  // Burst parameters are captured once; later input changes are invisible to the burst.
  always_comb begin
    num_d  = num_q;
    high_d = high_q;
    low_d  = low_q;
    sent_d = sent_q;
    if (accept) begin
      num_d  = num_clamp;
      high_d = high_fix;
      low_d  = low_fix;
      sent_d = '0;
    end
    if ((state_d == ST_HIGH) && (state_q != ST_HIGH)) begin
      sent_d = sent_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      num_q       <= '0;
      high_q      <= '0;
      low_q       <= '0;
      sent_q      <= '0;
      pulse_out_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      num_q       <= num_d;
      high_q      <= high_d;
      low_q       <= low_d;
      sent_q      <= sent_d;
      pulse_out_q <= pulse_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign pulse_out = pulse_out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sent      = sent_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed bench for pulse_train_gen with hand-computed pulse patterns and strobes.
// A rising-edge counter is looped back from pulse_out to check the emitted pulse count.
module tb_pulse_train_gen;

  localparam int CNT_W    = 4;
  localparam int PERIOD_W = 8;

  logic                clk;
  logic                rst_n;
  logic                start;
  logic                abort;
  logic [CNT_W-1:0]    num_pulses;
  logic [PERIOD_W-1:0] high_cycles;
  logic [PERIOD_W-1:0] low_cycles;
  logic                pulse_out;
  logic                busy;
  logic                done;
  logic [CNT_W-1:0]    sent;

  int n_checks;
  int n_fail;

  logic       cnt_clr;
  logic       pulse_prev;
  logic [7:0] edge_cnt;

  pulse_train_gen #(
    .MAX_PULSES (8),
    .PERIOD_W   (PERIOD_W),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .num_pulses  (num_pulses),
    .high_cycles (high_cycles),
    .low_cycles  (low_cycles),
    .pulse_out   (pulse_out),
    .busy        (busy),
    .done        (done),
    .sent        (sent)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter fed by the pulse train
  always @(posedge clk) begin
    if (cnt_clr) begin
      edge_cnt   <= '0;
      pulse_prev <= 1'b0;
    end else begin
      pulse_prev <= pulse_out;
      if (pulse_out && !pulse_prev) edge_cnt <= edge_cnt + 8'd1;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues start, then records pulse_out for cycles 1..ncyc (cycle 0 is the start cycle).
  task automatic burst(input logic [CNT_W-1:0] n, input logic [PERIOD_W-1:0] h,
                       input logic [PERIOD_W-1:0] l, input int ncyc,
                       output logic [63:0] pat, output int done_at, output int ndone);
    num_pulses  = n;
    high_cycles = h;
    low_cycles  = l;
    start       = 1'b1;
    tick();
    start   = 1'b0;
    pat     = '0;
    done_at = 0;
    ndone   = 0;
    for (int c = 1; c <= ncyc; c++) begin
      pat[c-1] = pulse_out;
      if (done) begin
        ndone++;
        if (done_at == 0) done_at = c;
      end
      if (c < ncyc) tick();
    end
  endtask

  logic [63:0] pat;
  int          done_at;
  int          ndone;
  int          seen;

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    num_pulses  = '0;
    high_cycles = '0;
    low_cycles  = '0;
    cnt_clr     = 1'b1;
    tick();
    tick();
    check_eq("rst_pulse_out", pulse_out, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_sent", sent, 0);
    rst_n = 1'b1;
    tick();

    // N=3 H=2 L=2: 1100110011 in cycles 1..10, done in cycle 11
    burst(3, 2, 2, 12, pat, done_at, ndone);
    check_eq("b322_pattern", pat[11:0], 12'h333);
    check_eq("b322_done_at", done_at, 11);
    check_eq("b322_done_cnt", ndone, 1);
    check_eq("b322_sent", sent, 3);

    // N=3 H=2 L=1: 11011011, burst 8 cycles, done in cycle 9
    burst(3, 2, 1, 10, pat, done_at, ndone);
    check_eq("b321_pattern", pat[9:0], 10'h0DB);
    check_eq("b321_done_at", done_at, 9);

    // Zero pulses: straight to DONE
    burst(0, 3, 3, 4, pat, done_at, ndone);
    check_eq("b0_pattern", pat[3:0], 4'h0);
    check_eq("b0_done_at", done_at, 1);
    check_eq("b0_done_cnt", ndone, 1);
    check_eq("b0_sent", sent, 0);

    // Count clamped to 8
    burst(12, 1, 1, 18, pat, done_at, ndone);
    check_eq("clamp_pulses", $countones(pat[17:0]), 8);
    check_eq("clamp_pattern", pat[17:0], 18'h05555);
    check_eq("clamp_done_at", done_at, 16);
    check_eq("clamp_sent", sent, 8);

    // Zero phase lengths behave as one cycle
    burst(2, 0, 0, 5, pat, done_at, ndone);
    check_eq("zero_len_pattern", pat[4:0], 5'h05);
    check_eq("zero_len_done_at", done_at, 4);

    // Abort during the second HIGH (cycles 7..9)
    num_pulses = 4; high_cycles = 3; low_cycles = 3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 8; c++) tick();
    check_eq("abort_pre_pulse", pulse_out, 1'b1);
    check_eq("abort_pre_sent", sent, 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("abort_pulse_out", pulse_out, 1'b0);
    check_eq("abort_done", done, 1'b1);
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_sent", sent, 2);
    tick();
    check_eq("abort_done_clear", done, 1'b0);
    check_eq("abort_sent_hold", sent, 2);

    // Abort on the last cycle of a HIGH phase wins over the phase change
    num_pulses = 2; high_cycles = 2; low_cycles = 2; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("abort_edge_pulse", pulse_out, 1'b0);
    check_eq("abort_edge_done", done, 1'b1);
    check_eq("abort_edge_sent", sent, 1);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("abort_idle_busy", busy, 1'b0);
    check_eq("abort_idle_done", done, 1'b0);

    // Start presented in DONE is not taken
    num_pulses = 0; start = 1'b1;
    tick();
    check_eq("done_state_done", done, 1'b0 | 1'b1 & done);
    num_pulses = 2;
    tick();
    start = 1'b0;
    check_eq("start_in_done_busy", busy, 1'b0);
    tick();
    check_eq("start_in_done_pulse", pulse_out, 1'b0);

    // Restart and input changes mid-burst are ignored, then reset mid-LOW
    num_pulses = 3; high_cycles = 2; low_cycles = 4; start = 1'b1;
    tick();
    num_pulses = 8; high_cycles = 1; low_cycles = 1;
    tick();
    tick();
    start = 1'b0;
    check_eq("restart_low_pulse", pulse_out, 1'b0);
    check_eq("restart_low_busy", busy, 1'b1);
    check_eq("restart_low_sent", sent, 1);
    for (int c = 3; c < 7; c++) tick();
    check_eq("restart_high_pulse", pulse_out, 1'b1);
    check_eq("restart_high_sent", sent, 2);
    tick();
    tick();
    tick();
    check_eq("mid_low_pulse", pulse_out, 1'b0);
    rst_n = 1'b0;
    tick();
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      if (done) seen++;
      tick();
    end
    check_eq("reset_pulse_out", pulse_out, 1'b0);
    check_eq("reset_busy", busy, 1'b0);
    check_eq("reset_sent", sent, 0);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (done || busy || pulse_out) seen++;
      tick();
    end
    check_eq("reset_no_done", seen, 0);

    // Loopback into the edge counter with N=5
    cnt_clr = 1'b0;
    num_pulses = 5; high_cycles = 2; low_cycles = 3; start = 1'b1;
    tick();
    start = 1'b0;
    seen = 0;
    for (int c = 0; c < 200; c++) begin
      if (done) begin
        seen = 1;
        break;
      end
      tick();
    end
    check_eq("loop_done_seen", seen, 1);
    check_eq("loop_edge_count", edge_cnt, 5);
    check_eq("loop_sent", sent, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
